// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide execute unit
//
// Radix-2 shift-add multiplier and restoring divider that share one
// 2*data_width accumulator. Sequence: IDLE -> CALC (data_width edges) -> FIX -> DONE.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   flush         synchronous abort of an in-flight op
//   in_valid      request, accepted when in_ready (IDLE) and no flush
//   in_ready      high only in IDLE
//   funct3        RV32M operation select
//   rs1v, rs2v    operand A (dividend / multiplicand), operand B (divisor / multiplier)
//   rd_in         destination register index
//   rdv, rd       write-back data and index, held until the next FIX
//   WEn           one-cycle write enable (result valid)
module muldiv_unit #(
   parameter int data_width = 32,
   parameter int idx_width  = 5,
   parameter int cnt_width  = $clog2(data_width) + 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [2:0]            funct3,
   input  logic [data_width-1:0] rs1v,
   input  logic [data_width-1:0] rs2v,
   input  logic [idx_width-1:0]  rd_in,
   output logic [data_width-1:0] rdv,
   output logic [idx_width-1:0]  rd,
   output logic                  WEn
);

   localparam logic [2:0] F_MUL    = 3'b000;
   localparam logic [2:0] F_MULH   = 3'b001;
   localparam logic [2:0] F_MULHSU = 3'b010;
   localparam logic [2:0] F_DIV    = 3'b100;
   localparam logic [2:0] F_REM    = 3'b110;

   localparam logic [data_width-1:0] all_ones = {data_width{1'b1}};
   localparam logic [data_width-1:0] int_min  = {1'b1, {(data_width-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t                  state, state_nxt;
   logic [cnt_width-1:0]    count;
   logic [2:0]              op;
   logic [idx_width-1:0]    rd_q;
   logic                    sign_a, sign_b;
   logic                    div_zero, div_ovf;
   logic [data_width-1:0]   a_raw;
   // Multiply: multiplicand magnitude. Divide: divisor magnitude.
   logic [data_width-1:0]   opnd;
   // Multiply: {partial product, multiplier}. Divide: {remainder, dividend/quotient}.
   logic [2*data_width-1:0] acc;

   logic                    accept;
   logic                    a_signed, b_signed, neg_a, neg_b;
   logic [data_width-1:0]   a_mag, b_mag;
   logic [data_width:0]     mul_sum;
   logic [data_width:0]     div_sh, div_diff;
   logic                    div_ge;
   logic [2*data_width-1:0] prod;
   logic [data_width-1:0]   quot, remd, result;

   assign accept   = (state == IDLE) && in_valid && !flush;
   assign in_ready = (state == IDLE);
   // A flush during DONE kills the write in that same cycle.
   assign WEn      = (state == DONE) && !flush;

   // Operand preparation at accept: magnitudes plus sign flags.
   always_comb begin
      a_signed = (funct3 == F_MUL) || (funct3 == F_MULH) || (funct3 == F_MULHSU) ||
                 (funct3 == F_DIV) || (funct3 == F_REM);
      b_signed = (funct3 == F_MUL) || (funct3 == F_MULH) ||
                 (funct3 == F_DIV) || (funct3 == F_REM);
      neg_a    = a_signed && rs1v[data_width-1];
      neg_b    = b_signed && rs2v[data_width-1];
      a_mag    = neg_a ? -rs1v : rs1v;
      b_mag    = neg_b ? -rs2v : rs2v;
   end

   // One iteration of each algorithm.
   always_comb begin
      mul_sum  = {1'b0, acc[2*data_width-1:data_width]} +
                 (acc[0] ? {1'b0, opnd} : {(data_width+1){1'b0}});
      div_sh   = {acc[2*data_width-1:data_width], acc[data_width-1]};
      div_diff = div_sh - {1'b0, opnd};
      div_ge   = !div_diff[data_width];
   end

   // Sign correction and special cases, consumed in FIX.
   always_comb begin
      prod = (sign_a ^ sign_b) ? -acc : acc;
      quot = (sign_a ^ sign_b) ? -acc[data_width-1:0] : acc[data_width-1:0];
      remd = sign_a ? -acc[2*data_width-1:data_width] : acc[2*data_width-1:data_width];
      if (!op[2]) begin
         result = (op == F_MUL) ? prod[data_width-1:0] : prod[2*data_width-1:data_width];
      end else if (!op[1]) begin
         if (div_zero)
            result = all_ones;
         else if (div_ovf && !op[0])
            result = int_min;
         else
            result = quot;
      end else begin
         if (div_zero)
            result = a_raw;
         else if (div_ovf && !op[0])
            result = '0;
         else
            result = remd;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept) state_nxt = CALC;
         CALC: if (flush) state_nxt = IDLE;
               else if (count == cnt_width'(data_width - 1)) state_nxt = FIX;
         FIX:  state_nxt = flush ? IDLE : DONE;
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count    <= '0;
         op       <= '0;
         rd_q     <= '0;
         sign_a   <= 1'b0;
         sign_b   <= 1'b0;
         div_zero <= 1'b0;
         div_ovf  <= 1'b0;
         a_raw    <= '0;
         opnd     <= '0;
         acc      <= '0;
         rdv      <= '0;
         rd       <= '0;
      end else begin
         if (accept) begin
            count    <= '0;
            op       <= funct3;
            rd_q     <= rd_in;
            sign_a   <= neg_a;
            sign_b   <= neg_b;
            div_zero <= (rs2v == '0);
            div_ovf  <= (rs1v == int_min) && (rs2v == all_ones);
            a_raw    <= rs1v;
            opnd     <= funct3[2] ? b_mag : a_mag;
            acc      <= {{data_width{1'b0}}, funct3[2] ? a_mag : b_mag};
         end else if (state == CALC) begin
            count <= count + 1'b1;
            if (op[2])
               acc <= {(div_ge ? div_diff[data_width-1:0] : div_sh[data_width-1:0]),
                       acc[data_width-2:0], div_ge};
            else
               acc <= {mul_sum, acc[data_width-1:1]};
         end
         if (state == FIX && !flush) begin
            rdv <= result;
            rd  <= rd_q;
         end
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - scoreboard testbench for muldiv_unit
module tb_muldiv_unit;

   localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
   localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [2:0]  funct3 = '0;
   logic [31:0] rs1v = '0, rs2v = '0;
   logic [4:0]  rd_in = '0;
   logic [31:0] rdv;
   logic [4:0]  rd;
   logic        WEn;

   muldiv_unit dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .funct3(funct3), .rs1v(rs1v), .rs2v(rs2v), .rd_in(rd_in),
      .rdv(rdv), .rd(rd), .WEn(WEn)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] v;
      int          due;
   } exp_t;
   exp_t sb[$];

   int n_cmp = 0;
   int n_bad = 0;
   int last_acc = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   // Monitor: every write-back must match the oldest outstanding expectation.
   always @(negedge clk) begin : mon
      exp_t e;
      if (WEn === 1'b1) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_wen: got rd=%0d rdv=%h, expected no write", rd, rdv);
         end else begin
            e = sb.pop_front();
            check("wb_rd", 32'(rd), 32'(e.rd));
            check("wb_rdv", rdv, e.v);
            check("wb_latency_cycle", cyc, e.due);
         end
      end
   end

   // Drives a request and waits for acceptance; in_valid is left high on return.
   task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] r, input logic [31:0] expv, input bit push);
      bit ok = 0;
      in_valid = 1'b1;
      funct3   = f;
      rs1v     = a;
      rs2v     = b;
      rd_in    = r;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1;
            break;
         end
      end
      if (!ok) begin
         n_cmp++;
         n_bad++;
         $display("FAIL accept_timeout: got in_ready=0 for 100 cycles, expected 1");
         in_valid = 1'b0;
         return;
      end
      last_acc = cyc + 1;
      if (push) sb.push_back('{r, expv, cyc + 1 + 33});
      @(posedge clk);
      #1;
      check("busy_after_accept", 32'(in_ready), 32'd0);
   endtask

   task automatic op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] r, input logic [31:0] expv);
      issue(f, a, b, r, expv, 1'b1);
      in_valid = 1'b0;
   endtask

   typedef struct {
      logic [2:0]  f;
      logic [31:0] a, b, e;
      logic [4:0]  r;
   } vec_t;

   vec_t vecs[$] = '{
      '{MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 5'd1},
      '{MULH,   32'h80000000, 32'h80000000, 32'h40000000, 5'd2},
      '{MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3},
      '{MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 5'd4},
      '{MULHU,  32'h12345678, 32'h00000010, 32'h00000001, 5'd0},
      '{DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 5'd5},
      '{REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 5'd6},
      '{DIVU,   32'd100,      32'd7,        32'd14,       5'd7},
      '{REMU,   32'd100,      32'd7,        32'd2,        5'd8},
      '{DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 5'd9},
      '{REMU,   32'd5,        32'd0,        32'd5,        5'd13},
      '{DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 5'd14},
      '{REM,    32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 5'd15},
      '{DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 5'd16},
      '{REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        5'd17}
   };

   initial begin
      int prev;
      #2;
      check("reset_in_ready", 32'(in_ready), 32'd1);
      check("reset_wen", 32'(WEn), 32'd0);
      check("reset_rdv", rdv, 32'd0);
      check("reset_rd", 32'(rd), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;

      foreach (vecs[i]) op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].e);

      // Back-to-back with in_valid held high throughout.
      issue(MUL, 32'd3, 32'd5, 5'd10, 32'd15, 1'b1);
      prev = last_acc;
      issue(DIV, 32'hFFFFFFEC, 32'd3, 5'd11, 32'hFFFFFFFA, 1'b1);
      check("b2b_spacing_1", 32'(last_acc - prev), 32'd35);
      prev = last_acc;
      issue(REM, 32'hFFFFFFEC, 32'd3, 5'd12, 32'hFFFFFFFE, 1'b1);
      check("b2b_spacing_2", 32'(last_acc - prev), 32'd35);
      in_valid = 1'b0;

      // Wait for the unit to go idle, then flush in IDLE must drop the request.
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (in_ready) break;
      end
      @(posedge clk);
      #1;
      funct3 = MUL; rs1v = 32'd2; rs2v = 32'd2; rd_in = 5'd20;
      in_valid = 1'b1;
      flush = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      flush = 1'b0;
      check("flush_idle_drop", 32'(in_ready), 32'd1);

      // Asynchronous reset mid-op at CALC count 10.
      issue(MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd21, 32'h0, 1'b0);
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check("rst_async_in_ready", 32'(in_ready), 32'd1);
      check("rst_async_wen", 32'(WEn), 32'd0);
      check("rst_async_rdv", rdv, 32'd0);
      #1 rst = 1'b0;
      @(posedge clk);
      #1;
      check("rst_next_in_ready", 32'(in_ready), 32'd1);
      op(DIVU, 32'd1000, 32'd10, 5'd22, 32'd100);

      // Flush while in FIX.
      issue(MUL, 32'd6, 32'd7, 5'd23, 32'h0, 1'b0);
      in_valid = 1'b0;
      repeat (32) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      check("flush_fix_in_ready", 32'(in_ready), 32'd1);
      op(REMU, 32'd1000, 32'd7, 5'd24, 32'd6);

      for (int i = 0; i < 200; i++) begin
         if (sb.size() == 0) break;
         @(negedge clk);
      end
      repeat (40) @(negedge clk);
      if (sb.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL outstanding_results: got %0d missing writes, expected 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
